bus_to_stream_bridge: RTL and testbench
=======================================

// Module: bus_to_stream_bridge
// PURPOSE
//  Bus-write to stream bridge: the playback-direction counterpart of the capture bridge.
//  - CPU writes samples over the simple bus into an internal DEPTH x DATA_SIZE FIFO.
//  - Block drives them out on a valid/ready stream toward the audio output path.
//  - Provides fill status, sticky overflow/underrun flags and a low-water refill IRQ.
// PARAMETERS
//  DATA_SIZE   28                sample width (<=32)
//  DEPTH       512               FIFO depth in words (power of 2, <=32768)
//  ADDR_WIDTH  $clog2(DEPTH)     FIFO pointer width
//  LOW_WATER   DEPTH/4           IRQ threshold: asserts when occupancy <= LOW_WATER
// PORTS
//  clk           in   1          system clock (50 MHz); single clock domain
//  rst           in   1          synchronous, active-high reset
//  chipselect    in   1          bus select
//  address       in   2          register index
//  write         in   1          bus write strobe
//  write_data    in   32         bus write data
//  read          in   1          bus read strobe
//  read_data     out  32         registered read data
//  sink_valid    out  1          output word valid
//  sink_data     out  DATA_SIZE  output sample
//  sink_ready    in   1          downstream accepts when high with sink_valid
//  irq           out  1          level interrupt (low-water refill request)
// BEHAVIOUR
//  Reset: ptrs, cnt=0; CTRL=0; flags=0; read_data=0, sink_valid=0, sink_data=0, irq=0.
//  Registers (access = chipselect & write/read):
//   0 DATA   W: push write_data[DATA_SIZE-1:0]. If full: drop word, set OVF. R: 0.
//   1 STATUS R: [15:0]=cnt (zero-ext), [16]=empty, [17]=full, [18]=OVF, [19]=UDR,
//              [20]=cnt<=LOW_WATER, [21]=out_valid. Writes ignored.
//   2 CTRL   RW: [0]=enable, [1]=irq_en. W-only [2]=flush, self-clearing, reads 0.
//   3 CLEAR  W: bit0=1 clears OVF, bit1=1 clears UDR. R: 0.
//  Read path: read_data is registered; value appears the cycle after the read strobe.
//   - Reads have no side effects.
//   - Read and write in the same cycle: both serviced.
//  FIFO push: registered at the edge of the write cycle; cnt increments.
//   - A push when full is rejected even if a pop happens in the same cycle.
//  Output stage, 2 states: OUT_EMPTY and OUT_FULL.
//   - OUT_EMPTY -> OUT_FULL: enable & !fifo_empty. Pop mem[rd_ptr] into sink_data, rd_ptr+1.
//   - OUT_FULL & sink_ready:
//     - if enable & !fifo_empty: pop the next word the same edge and stay OUT_FULL
//       (back-to-back, 1 word/cycle);
//     - else go to OUT_EMPTY.
//   - OUT_FULL & !sink_ready: sink_data and sink_valid held stable.
//  Latency: a word pushed at edge E into an empty system (enable=1) gives sink_valid=1
//   after edge E+1.
//  Simultaneous push and pop: cnt unchanged; pointers both advance.
//  Pointer wrap: pointers wrap modulo DEPTH. cnt spans 0..DEPTH; full = (cnt==DEPTH).
//  UDR (sticky): set any cycle with enable & sink_ready & OUT_EMPTY & fifo_empty.
//  enable=0:
//   - no new pops;
//   - a word already in OUT_FULL stays valid until accepted;
//   - UDR is not set.
//  flush:
//   - sets ptrs and cnt to 0 at the write edge;
//   - OUT_FULL word is retained (handshake never retracted);
//   - a DATA push in the same cycle is lost (flush wins).
//  irq: registered, = irq_en & enable & (cnt<=LOW_WATER); updates 1 cycle after cnt.
//  Reset mid-transfer: all state cleared next edge; sink_valid drops regardless of sink_ready.
// TESTING
//  T1: enable=1, sink_ready=1; write 0x0ABCDEF to DATA
//      -> sink_valid=1, sink_data=0x0ABCDEF 2 cycles later; held 1 cycle; cnt returns to 0.
//  T2: enable=0; write DEPTH+1 words (value i)
//      -> STATUS full=1, OVF=1, cnt=DEPTH;
//      then enable=1, sink_ready=1 -> words 0..DEPTH-1 emerge back-to-back in order.
//  T3: sink_ready toggled pseudo-randomly with 1000 writes
//      -> every word seen exactly once, in order; sink_data stable while valid & !ready.
//  T4: irq_en=1, enable=1; fill to LOW_WATER+1, drain
//      -> irq rises 1 cycle after cnt==LOW_WATER; writing CTRL irq_en=0 drops it next cycle.
//  T5: enable=1, sink_ready=1, FIFO empty -> UDR=1; write CLEAR=2 -> UDR=0;
//      flush with 5 words queued -> cnt=0, only the word held in the output stage is delivered.
//  T6: assert rst while OUT_FULL with sink_ready=0
//      -> sink_valid=0, cnt=0, read_data=0 next cycle; wrap test of 3*DEPTH words passes.

Source files
------------

// File: rtl/bus_to_stream_bridge.sv
// Playback bridge: CPU writes samples over a simple register bus into a FIFO,
// which is drained onto a valid/ready stream with fill status, sticky error flags and a refill IRQ.
module bus_to_stream_bridge #(
   parameter int DATA_SIZE  = 28,
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LOW_WATER  = DEPTH / 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 chipselect_i,
   input  logic [1:0]           address_i,
   input  logic                 write_i,
   input  logic [31:0]          write_data_i,
   input  logic                 read_i,
   output logic [31:0]          read_data_o,
   output logic                 sink_valid_o,
   output logic [DATA_SIZE-1:0] sink_data_o,
   input  logic                 sink_ready_i,
   output logic                 irq_o
);

   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_WATER);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_CLEAR  = 2'd3;

   typedef enum logic {
      OUT_EMPTY,
      OUT_FULL
   } outState_e;

   logic [DATA_SIZE-1:0]  mem [DEPTH];

   outState_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_SIZE-1:0]  sinkData_q, sinkData_d;
   logic                  enable_q, enable_d;
   logic                  irqEn_q, irqEn_d;
   logic                  ovf_q, ovf_d;
   logic                  udr_q, udr_d;
   logic                  irq_q, irq_d;
   logic [31:0]           readData_q, readData_d;

   logic                  busWr;
   logic                  busRd;
   logic                  fifoEmpty;
   logic                  fifoFull;
   logic                  lowWater;
   logic                  flush;
   logic                  dataWr;
   logic                  push;
   logic                  popCond;
   logic                  pop;
   logic [DATA_SIZE-1:0]  wrWord;
   logic [31:0]           statusWord;

   // Bus decode; flush suppresses both the push and any pop on its edge.
   always_comb begin
      busWr     = chipselect_i & write_i;
      busRd     = chipselect_i & read_i;
      fifoEmpty = (cnt_q == '0);
      fifoFull  = (cnt_q == DEPTH_C);
      lowWater  = (cnt_q <= LOW_C);
      wrWord    = DATA_SIZE'(write_data_i);
      flush     = busWr & (address_i == REG_CTRL) & write_data_i[2];
      dataWr    = busWr & (address_i == REG_DATA);
      push      = dataWr & ~fifoFull & ~flush;
      popCond   = enable_q & ~fifoEmpty & ~flush;
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wrPtr_q] <= wrWord;
      end
   end

   // Output stage: a word once presented stays until accepted, even across disable or flush.
   always_comb begin
      state_d    = state_q;
      sinkData_d = sinkData_q;
      pop        = 1'b0;
      unique case (state_q)
         OUT_EMPTY: begin
            if (popCond) begin
               pop        = 1'b1;
               sinkData_d = mem[rdPtr_q];
               state_d    = OUT_FULL;
            end
         end
         OUT_FULL: begin
            if (sink_ready_i) begin
               if (popCond) begin
                  pop        = 1'b1;
                  sinkData_d = mem[rdPtr_q];
               end else begin
                  state_d = OUT_EMPTY;
               end
            end
         end
      endcase
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      cnt_d   = cnt_q;
      if (push) begin
         wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         cnt_d   = '0;
      end
   end

   // Control and sticky flags; a set condition on the same edge as a clear wins.
   always_comb begin
      enable_d = enable_q;
      irqEn_d  = irqEn_q;
      ovf_d    = ovf_q;
      udr_d    = udr_q;
      if (busWr && (address_i == REG_CTRL)) begin
         enable_d = write_data_i[0];
         irqEn_d  = write_data_i[1];
      end
      if (busWr && (address_i == REG_CLEAR)) begin
         if (write_data_i[0]) begin
            ovf_d = 1'b0;
         end
         if (write_data_i[1]) begin
            udr_d = 1'b0;
         end
      end
      if (dataWr && fifoFull) begin
         ovf_d = 1'b1;
      end
      if (enable_q && sink_ready_i && (state_q == OUT_EMPTY) && fifoEmpty) begin
         udr_d = 1'b1;
      end
      irq_d = irqEn_q & enable_q & lowWater;
   end

   always_comb begin
      statusWord               = '0;
      statusWord[CNT_W-1:0]    = cnt_q;
      statusWord[16]           = fifoEmpty;
      statusWord[17]           = fifoFull;
      statusWord[18]           = ovf_q;
      statusWord[19]           = udr_q;
      statusWord[20]           = lowWater;
      statusWord[21]           = (state_q == OUT_FULL);
      readData_d = readData_q;
      if (busRd) begin
         unique case (address_i)
            REG_DATA:   readData_d = '0;
            REG_STATUS: readData_d = statusWord;
            REG_CTRL:   readData_d = {30'd0, irqEn_q, enable_q};
            REG_CLEAR:  readData_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= OUT_EMPTY;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         cnt_q      <= '0;
         sinkData_q <= '0;
         enable_q   <= 1'b0;
         irqEn_q    <= 1'b0;
         ovf_q      <= 1'b0;
         udr_q      <= 1'b0;
         irq_q      <= 1'b0;
         readData_q <= '0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         cnt_q      <= cnt_d;
         sinkData_q <= sinkData_d;
         enable_q   <= enable_d;
         irqEn_q    <= irqEn_d;
         ovf_q      <= ovf_d;
         udr_q      <= udr_d;
         irq_q      <= irq_d;
         readData_q <= readData_d;
      end
   end

   assign read_data_o  = readData_q;
   assign sink_valid_o = (state_q == OUT_FULL);
   assign sink_data_o  = sinkData_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_bus_to_stream_bridge.sv
// Bench for bus_to_stream_bridge: scoreboard of written words checked against stream output,
// plus register, IRQ, flag, flush and reset scenarios.
module tb_bus_to_stream_bridge;

   localparam int DATA_SIZE = 28;
   localparam int DEPTH     = 512;
   localparam int LOW_WATER = DEPTH / 4;

   logic                 clk;
   logic                 rst;
   logic                 chipselect;
   logic [1:0]           address;
   logic                 write;
   logic [31:0]          writeData;
   logic                 read;
   logic [31:0]          readData;
   logic                 sinkValid;
   logic [DATA_SIZE-1:0] sinkData;
   logic                 sinkReady;
   logic                 irq;

   int total = 0;
   int bad   = 0;

   logic [DATA_SIZE-1:0] sbQ[$];
   logic                 prevHold = 1'b0;
   logic [DATA_SIZE-1:0] prevData = '0;
   logic [DATA_SIZE-1:0] expWord;

   bus_to_stream_bridge #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .LOW_WATER (LOW_WATER)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .chipselect_i (chipselect),
      .address_i    (address),
      .write_i      (write),
      .write_data_i (writeData),
      .read_i       (read),
      .read_data_o  (readData),
      .sink_valid_o (sinkValid),
      .sink_data_o  (sinkData),
      .sink_ready_i (sinkReady),
      .irq_o        (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Stream monitor: every accepted word must match the scoreboard head, and a stalled word must not move.
   always @(negedge clk) begin
      if (rst) begin
         prevHold = 1'b0;
      end else begin
         if (prevHold) begin
            total++;
            if (sinkValid !== 1'b1 || sinkData !== prevData) begin
               bad++;
               $display("[TB] FAIL hold_stable valid=%0b data=%h want valid=1 data=%h", sinkValid, sinkData, prevData);
            end
         end
         if (sinkValid === 1'b1 && sinkReady === 1'b1) begin
            total++;
            if (sbQ.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_word got %h want none", sinkData);
            end else begin
               expWord = sbQ.pop_front();
               if (sinkData !== expWord) begin
                  bad++;
                  $display("[TB] FAIL stream_data got %h want %h", sinkData, expWord);
               end
            end
         end
         prevHold = (sinkValid === 1'b1) && (sinkReady === 1'b0);
         prevData = sinkData;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writeData  = d;
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
      writeData  = '0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      chipselect = 1'b1;
      read       = 1'b1;
      address    = a;
      tick();
      chipselect = 1'b0;
      read       = 1'b0;
      d          = readData;
   endtask

   task automatic waitDrain(input int budget, output int cycles);
      cycles = 0;
      while (sbQ.size() != 0 && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rst = 1'b1;
      repeat (2) tick();
      total++;
      if (sinkValid !== 1'b0 || sinkData !== '0 || irq !== 1'b0 || readData !== 32'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs valid=%0b data=%h irq=%0b rdata=%h want all zero", sinkValid, sinkData, irq, readData);
      end
      rst = 1'b0;
      busRead(2'd1, rd);
      total++;
      if (rd !== 32'h0011_0000) begin
         bad++;
         $display("[TB] FAIL reset_status got %h want %h", rd, 32'h0011_0000);
      end
      busRead(2'd2, rd);
      total++;
      if (rd !== 32'd0) begin
         bad++;
         $display("[TB] FAIL reset_ctrl got %h want 0", rd);
      end
   endtask

   task automatic test_single();
      logic [31:0] rd;
      sinkReady = 1'b1;
      busWrite(2'd2, 32'h1);
      sbQ.push_back(28'h0ABCDEF);
      busWrite(2'd0, 32'h0ABCDEF);
      total++;
      if (sinkValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_early_valid got %0b want 0", sinkValid);
      end
      tick();
      total++;
      if (sinkValid !== 1'b1 || sinkData !== 28'h0ABCDEF) begin
         bad++;
         $display("[TB] FAIL single_out valid=%0b data=%h want valid=1 data=0abcdef", sinkValid, sinkData);
      end
      tick();
      total++;
      if (sinkValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_one_cycle valid=%0b want 0", sinkValid);
      end
      busRead(2'd1, rd);
      total++;
      if (rd !== 32'h0019_0000) begin
         bad++;
         $display("[TB] FAIL single_status got %h want %h", rd, 32'h0019_0000);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      int          cycles;
      busWrite(2'd2, 32'h0);
      busWrite(2'd3, 32'h3);
      sinkReady = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         if (i < DEPTH) sbQ.push_back(DATA_SIZE'(i));
         busWrite(2'd0, 32'(i));
      end
      busRead(2'd1, rd);
      total++;
      if (rd !== 32'h0006_0200) begin
         bad++;
         $display("[TB] FAIL overflow_status got %h want %h", rd, 32'h0006_0200);
      end
      busWrite(2'd2, 32'h1);
      waitDrain(4 * DEPTH, cycles);
      total++;
      if (sbQ.size() != 0 || cycles != DEPTH + 1) begin
         bad++;
         $display("[TB] FAIL overflow_drain left=%0d cycles=%0d want left=0 cycles=%0d", sbQ.size(), cycles, DEPTH + 1);
      end
   endtask

   task automatic test_random();
      logic [DATA_SIZE-1:0] w;
      int                   cycles;
      busWrite(2'd2, 32'h1);
      for (int i = 0; i < 1000; i++) begin
         int guard = 0;
         while (sbQ.size() > DEPTH - 4 && guard < 4 * DEPTH) begin
            sinkReady = 1'b1;
            tick();
            guard++;
         end
         if ($urandom_range(0, 3) == 0) begin
            sinkReady = 1'($urandom_range(0, 1));
            tick();
         end
         sinkReady = ($urandom_range(0, 3) != 0);
         w = DATA_SIZE'($urandom);
         sbQ.push_back(w);
         busWrite(2'd0, {4'd0, w});
      end
      sinkReady = 1'b1;
      waitDrain(4 * DEPTH, cycles);
      total++;
      if (sbQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL random_drain left=%0d want 0", sbQ.size());
      end
   endtask

   task automatic test_irq();
      int cycles;
      sinkReady = 1'b0;
      busWrite(2'd2, 32'h2);
      for (int i = 0; i <= LOW_WATER; i++) begin
         sbQ.push_back(DATA_SIZE'(32'h2000 + i));
         busWrite(2'd0, 32'h2000 + i);
      end
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("[TB] FAIL irq_gated_by_enable got %0b want 0", irq);
      end
      busWrite(2'd2, 32'h3);
      tick();
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("[TB] FAIL irq_above_low got %0b want 0", irq);
      end
      tick();
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("[TB] FAIL irq_rise got %0b want 1", irq);
      end
      busWrite(2'd2, 32'h1);
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("[TB] FAIL irq_before_drop got %0b want 1", irq);
      end
      tick();
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("[TB] FAIL irq_drop got %0b want 0", irq);
      end
      sinkReady = 1'b1;
      waitDrain(4 * DEPTH, cycles);
      total++;
      if (sbQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL irq_drain left=%0d want 0", sbQ.size());
      end
   endtask

   task automatic test_udr_flush();
      logic [31:0] rd;
      int          cycles;
      tick();
      busRead(2'd1, rd);
      total++;
      if (rd[19] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL udr_set got %0b want 1", rd[19]);
      end
      sinkReady = 1'b0;
      busWrite(2'd3, 32'h2);
      busRead(2'd1, rd);
      total++;
      if (rd[19:18] !== 2'b01) begin
         bad++;
         $display("[TB] FAIL udr_clear udr_ovf=%b want 01", rd[19:18]);
      end
      busWrite(2'd2, 32'h0);
      for (int k = 0; k < 5; k++) begin
         if (k == 0) sbQ.push_back(DATA_SIZE'(32'h100));
         busWrite(2'd0, 32'h100 + k);
      end
      busWrite(2'd2, 32'h1);
      tick();
      tick();
      busWrite(2'd2, 32'h5);
      busRead(2'd1, rd);
      total++;
      if (rd !== 32'h0035_0000) begin
         bad++;
         $display("[TB] FAIL flush_status got %h want %h", rd, 32'h0035_0000);
      end
      busRead(2'd2, rd);
      total++;
      if (rd !== 32'h1) begin
         bad++;
         $display("[TB] FAIL flush_ctrl_readback got %h want 1", rd);
      end
      sinkReady = 1'b1;
      waitDrain(10, cycles);
      repeat (4) tick();
      total++;
      if (sbQ.size() != 0 || sinkValid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_delivery left=%0d valid=%0b want left=0 valid=0", sbQ.size(), sinkValid);
      end
   endtask

   task automatic test_reset_mid_and_wrap();
      logic [31:0] rd;
      int          cycles;
      sinkReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) sbQ.push_back(DATA_SIZE'(32'h300));
         busWrite(2'd0, 32'h300 + k);
      end
      tick();
      tick();
      total++;
      if (sinkValid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midreset_pre_valid got %0b want 1", sinkValid);
      end
      busRead(2'd1, rd);
      rst = 1'b1;
      tick();
      total++;
      if (sinkValid !== 1'b0 || readData !== 32'd0 || irq !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs valid=%0b rdata=%h irq=%0b want all zero", sinkValid, readData, irq);
      end
      rst = 1'b0;
      sbQ.delete();
      busRead(2'd1, rd);
      total++;
      if (rd !== 32'h0011_0000) begin
         bad++;
         $display("[TB] FAIL midreset_status got %h want %h", rd, 32'h0011_0000);
      end
      sinkReady = 1'b1;
      busWrite(2'd2, 32'h1);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         sbQ.push_back(DATA_SIZE'(32'h0A00_0000 + i));
         busWrite(2'd0, 32'h0A00_0000 + i);
      end
      waitDrain(64, cycles);
      total++;
      if (sbQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL wrap_drain left=%0d want 0", sbQ.size());
      end
      busRead(2'd1, rd);
      total++;
      if (rd !== 32'h0019_0000) begin
         bad++;
         $display("[TB] FAIL wrap_status got %h want %h", rd, 32'h0019_0000);
      end
   endtask

   initial begin
      rst        = 1'b1;
      chipselect = 1'b0;
      address    = 2'd0;
      write      = 1'b0;
      writeData  = '0;
      read       = 1'b0;
      sinkReady  = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_random();
      test_irq();
      test_udr_flush();
      test_reset_mid_and_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
